// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response signals of alu_cmd_sequencer.
// The sequencer uses the slave modport; the command source, ALU and consumer use master.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_opcode;
  logic [1:0] cmd_a;
  logic [1:0] cmd_b;
  logic [1:0] alu_opcode;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [1:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_result;
  logic [1:0] rsp_opcode;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_result, rsp_opcode
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_result, rsp_opcode
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a FIFO, feeds the head entry to an external combinational
// ALU and registers the result into a single-entry response slot.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_cmd_sequencer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t        state_q, state_d;
  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [5:0]    head;
  logic          full, empty, push, pop, slot_free;
  logic          rsp_valid;
  logic [1:0]    rsp_result, rsp_opcode;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign slot_free = !rsp_valid || bus.rsp_ready;
  assign push      = bus.cmd_valid && !full;
  assign pop       = !empty && slot_free;
  assign head      = mem[rd_ptr];

  assign bus.cmd_ready  = !full;
  assign bus.alu_opcode = empty ? '0 : head[5:4];
  assign bus.alu_a      = empty ? '0 : head[3:2];
  assign bus.alu_b      = empty ? '0 : head[1:0];
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_opcode = rsp_opcode;

  // Storage is not reset; pointers and count alone define the valid entries.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_opcode <= '0;
    end else if (pop) begin
      rsp_valid  <= 1'b1;
      rsp_result <= bus.alu_result;
      rsp_opcode <= head[5:4];
    end else if (rsp_valid && bus.rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = RUN;
      RUN: begin
        if (rsp_valid && !bus.rsp_ready && !empty)
          state_d = STALL;
        else if (empty && !push && slot_free)
          state_d = IDLE;
      end
      STALL:   if (bus.rsp_ready) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a negedge monitor scores every
// response against commands recorded at acceptance; scenario tasks check timing inline.
module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] count;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] sb[$];

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] alu_ref(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return ~a;
      default: return {1'b0, |b};
    endcase
  endfunction

  always_comb bus.alu_result = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);

  // Scoreboard monitor: handshakes are sampled half a cycle before the edge that takes them.
  always @(negedge clk) begin
    logic [3:0] exp;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got op=%0d res=%0d, required no response", bus.rsp_opcode, bus.rsp_result);
        end else begin
          exp = sb.pop_front();
          if ({bus.rsp_opcode, bus.rsp_result} !== exp) begin
            errors++;
            $display("FAIL rsp_order: got op=%0d res=%0d, required op=%0d res=%0d",
                     bus.rsp_opcode, bus.rsp_result, exp[3:2], exp[1:0]);
          end
        end
      end
      if (bus.cmd_valid && bus.cmd_ready)
        sb.push_back({bus.cmd_opcode, alu_ref(bus.cmd_opcode, bus.cmd_a, bus.cmd_b)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
    bus.cmd_valid  = v;
    bus.cmd_opcode = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
  endtask

  // Presents n commands in order, holding each until accepted; leaves cmd_valid low.
  task automatic drive_n(input int n, input int base, output int sent);
    int cyc = 0;
    logic acc;
    sent = 0;
    while (sent < n && cyc < 50) begin
      set_cmd(1'b1, 2'((base + sent) % 4), 2'(base + sent), 2'(3 - sent));
      @(negedge clk);
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    set_cmd(1'b0, 2'd0, 2'd0, 2'd0);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    bus.rsp_ready = 1'b1;
    while ((sb.size() != 0 || bus.rsp_valid) && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (sb.size() != 0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got pending=%0d rsp_valid=%0b, required 0 and 0", name, sb.size(), bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    set_cmd(1'b0, 2'd0, 2'd0, 2'd0);
    repeat (3) tick();
    checks++;
    if (count !== 3'd0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got count=%0d rsp_valid=%0b, required 0 and 0", count, bus.rsp_valid);
    end
    checks++;
    if ({bus.rsp_result, bus.rsp_opcode} !== 4'd0 || {bus.alu_opcode, bus.alu_a, bus.alu_b} !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rsp=%h alu=%h, required 0 and 0",
               {bus.rsp_result, bus.rsp_opcode}, {bus.alu_opcode, bus.alu_a, bus.alu_b});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %0b, required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_cmd(1'b1, 2'd0, 2'd3, 2'd2);
    tick();
    set_cmd(1'b0, 2'd0, 2'd0, 2'd0);
    checks++;
    if (bus.rsp_valid !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_edge1: got rsp_valid=%0b count=%0d, required 0 and 1", bus.rsp_valid, count);
    end
    checks++;
    if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== {2'd0, 2'd3, 2'd2}) begin
      errors++;
      $display("FAIL single_alu_head: got %h, required %h", {bus.alu_opcode, bus.alu_a, bus.alu_b}, {2'd0, 2'd3, 2'd2});
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 2'd1 || bus.rsp_opcode !== 2'd0) begin
      errors++;
      $display("FAIL single_rsp: got v=%0b res=%0d op=%0d, required v=1 res=1 op=0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_opcode);
    end
    checks++;
    if (count !== 3'd0 || {bus.alu_opcode, bus.alu_a, bus.alu_b} !== 6'd0) begin
      errors++;
      $display("FAIL single_empty: got count=%0d alu=%h, required 0 and 0", count, {bus.alu_opcode, bus.alu_a, bus.alu_b});
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_clear: got rsp_valid=%0b, required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops[3] = '{2'd1, 2'd2, 2'd3};
    logic [1:0] as[3]  = '{2'd1, 2'd1, 2'd0};
    logic [1:0] bs[3]  = '{2'd2, 2'd0, 2'd2};
    logic [1:0] exp[3] = '{2'd3, 2'd2, 2'd1};
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_cmd(1'b1, ops[i], as[i], bs[i]);
      else       set_cmd(1'b0, 2'd0, 2'd0, 2'd0);
      tick();
      if (i > 0) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== exp[i-1] || bus.rsp_opcode !== ops[i-1]) begin
          errors++;
          $display("FAIL b2b_rsp%0d: got v=%0b res=%0d op=%0d, required v=1 res=%0d op=%0d",
                   i - 1, bus.rsp_valid, bus.rsp_result, bus.rsp_opcode, exp[i-1], ops[i-1]);
        end
      end
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    int sent;
    logic [1:0] held;
    bus.rsp_ready = 1'b0;
    drive_n(5, 0, sent);
    checks++;
    if (sent != 5) begin
      errors++;
      $display("FAIL bp_accept: got %0d commands accepted, required 5", sent);
    end
    checks++;
    if (count !== 3'd4 || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: got count=%0d cmd_ready=%0b rsp_valid=%0b, required 4 0 1", count, bus.cmd_ready, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_result !== alu_ref(2'd0, 2'd0, 2'd3) || bus.rsp_opcode !== 2'd0) begin
      errors++;
      $display("FAIL bp_first_rsp: got res=%0d op=%0d, required res=%0d op=0", bus.rsp_result, bus.rsp_opcode, alu_ref(2'd0, 2'd0, 2'd3));
    end
    held = bus.rsp_result;
    set_cmd(1'b1, 2'd3, 2'd3, 2'd3);
    repeat (2) tick();
    checks++;
    if (count !== 3'd4 || bus.rsp_result !== held || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall_hold: got count=%0d res=%0d v=%0b, required 4 %0d 1", count, bus.rsp_result, bus.rsp_valid, held);
    end
    set_cmd(1'b0, 2'd0, 2'd0, 2'd0);
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if (count !== 3'd3 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after_pop: got count=%0d cmd_ready=%0b, required 3 1", count, bus.cmd_ready);
    end
    drain("bp");
    checks++;
    if (count !== 3'd0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_empty: got count=%0d cmd_ready=%0b, required 0 1", count, bus.cmd_ready);
    end
  endtask

  task automatic test_simultaneous();
    int sent;
    bus.rsp_ready = 1'b0;
    drive_n(3, 1, sent);
    checks++;
    if (sent != 3 || count !== 3'd2 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_setup: got sent=%0d count=%0d v=%0b, required 3 2 1", sent, count, bus.rsp_valid);
    end
    set_cmd(1'b1, 2'd0, 2'd1, 2'd1);
    bus.rsp_ready = 1'b1;
    tick();
    set_cmd(1'b0, 2'd0, 2'd0, 2'd0);
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL simul_count: got %0d, required 2", count);
    end
    drain("simul");
  endtask

  task automatic test_wrap();
    int sent = 0;
    int cyc = 0;
    logic acc;
    logic [1:0] op = 2'($urandom_range(0, 3));
    logic [1:0] a  = 2'($urandom_range(0, 3));
    logic [1:0] b  = 2'($urandom_range(0, 3));
    while ((sent < 10 || sb.size() != 0 || bus.rsp_valid) && cyc < 300) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      if (sent < 10) set_cmd(1'b1, op, a, b);
      else           set_cmd(1'b0, 2'd0, 2'd0, 2'd0);
      @(negedge clk);
      acc = bus.cmd_valid && bus.cmd_ready;
      checks++;
      if (count > 3'd4) begin
        errors++;
        $display("FAIL wrap_count: got %0d, required <= 4", count);
      end
      tick();
      cyc++;
      if (acc) begin
        sent++;
        op = 2'($urandom_range(0, 3));
        a  = 2'($urandom_range(0, 3));
        b  = 2'($urandom_range(0, 3));
      end
    end
    set_cmd(1'b0, 2'd0, 2'd0, 2'd0);
    checks++;
    if (sent != 10 || sb.size() != 0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: got sent=%0d pending=%0d, required 10 and 0", sent, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int sent;
    bus.rsp_ready = 1'b0;
    drive_n(4, 2, sent);
    checks++;
    if (count !== 3'd3 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: got count=%0d v=%0b, required 3 1", count, bus.rsp_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (count !== 3'd0 || bus.rsp_valid !== 1'b0 || {bus.alu_opcode, bus.alu_a, bus.alu_b} !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_clear: got count=%0d v=%0b alu=%h, required 0 0 0",
               count, bus.rsp_valid, {bus.alu_opcode, bus.alu_a, bus.alu_b});
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || {bus.rsp_result, bus.rsp_opcode} !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_regs: got cmd_ready=%0b rsp=%h, required 1 0", bus.cmd_ready, {bus.rsp_result, bus.rsp_opcode});
    end
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    set_cmd(1'b1, 2'd1, 2'd0, 2'd1);
    tick();
    set_cmd(1'b0, 2'd0, 2'd0, 2'd0);
    checks++;
    if (bus.rsp_valid !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_push: got v=%0b count=%0d, required 0 1", bus.rsp_valid, count);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 2'd3 || bus.rsp_opcode !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_rsp: got v=%0b res=%0d op=%0d, required 1 3 1", bus.rsp_valid, bus.rsp_result, bus.rsp_opcode);
    end
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
